// File: rtl/s2mm_sample_packetizer_if.sv
// Sample-in / AXI4-Stream-out bundle of the S2MM packetizer, including its config and status lines.
// The master modport is the packetizer; the slave modport is whatever drives samples and consumes beats.
interface s2mm_sample_packetizer_if #(
    parameter int OVF_WIDTH = 16
);
    logic                 CFG_WR;
    logic [31:0]          CFG_WDATA;
    logic [31:0]          SAMPLE_DATA;
    logic                 SAMPLE_VALID;
    logic [63:0]          M_AXIS_TDATA;
    logic [7:0]           M_AXIS_TKEEP;
    logic                 M_AXIS_TVALID;
    logic                 M_AXIS_TREADY;
    logic                 M_AXIS_TLAST;
    logic                 BUSY;
    logic                 PKT_DONE;
    logic                 CFG_ERR;
    logic [OVF_WIDTH-1:0] OVF_CNT;

    modport master (
        input  CFG_WR,
        input  CFG_WDATA,
        input  SAMPLE_DATA,
        input  SAMPLE_VALID,
        input  M_AXIS_TREADY,
        output M_AXIS_TDATA,
        output M_AXIS_TKEEP,
        output M_AXIS_TVALID,
        output M_AXIS_TLAST,
        output BUSY,
        output PKT_DONE,
        output CFG_ERR,
        output OVF_CNT
    );

    modport slave (
        output CFG_WR,
        output CFG_WDATA,
        output SAMPLE_DATA,
        output SAMPLE_VALID,
        output M_AXIS_TREADY,
        input  M_AXIS_TDATA,
        input  M_AXIS_TKEEP,
        input  M_AXIS_TVALID,
        input  M_AXIS_TLAST,
        input  BUSY,
        input  PKT_DONE,
        input  CFG_ERR,
        input  OVF_CNT
    );
endinterface

// File: rtl/s2mm_sample_packetizer.sv
// Packs 32-bit sample pairs into 64-bit beats and emits one TLAST-terminated AXI4-Stream packet per arm.
//   state    | meaning
//   ST_IDLE  | waiting for an arm write; samples ignored
//   ST_RUN   | packing samples into beats until the last-flagged beat enters the FIFO
//   ST_DRAIN | samples ignored; waiting for the last beat to handshake
module s2mm_sample_packetizer #(
    parameter int FIFO_DEPTH = 16,
    parameter int OVF_WIDTH  = 16
) (
    input  logic                           M_AXIS_ACLK,
    input  logic                           M_AXIS_ARESET,
    s2mm_sample_packetizer_if.master       bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [15:0]          beats_m1;
    logic [15:0]          beat_cnt;
    logic [31:0]          half_data;
    logic                 half_vld;

    logic [64:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     rd_ptr_nxt;
    logic [PTR_W:0]       count;
    logic [PTR_W:0]       cnt_after_pop;
    logic [63:0]          out_data;
    logic                 out_last;
    logic                 out_vld;

    logic                 pkt_done_r;
    logic                 cfg_err_r;
    logic [OVF_WIDTH-1:0] ovf_cnt;

    logic                 cfg_arm;
    logic                 cfg_clr;
    logic                 pop;
    logic                 fifo_full;
    logic                 busy;
    logic                 arm_accept;
    logic                 arm_reject;
    logic                 sample_take;
    logic                 drain_done;
    logic                 pair_done;
    logic                 beat_wr;
    logic                 beat_drop;
    logic                 beat_is_last;
    logic [64:0]          wr_beat;
    logic                 cfg_unused;

    assign cfg_arm      = bus.CFG_WR & bus.CFG_WDATA[16];
    assign cfg_clr      = bus.CFG_WR & ~bus.CFG_WDATA[16];
    assign cfg_unused   = ^bus.CFG_WDATA[31:17];
    assign pop          = out_vld & bus.M_AXIS_TREADY;
    assign fifo_full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign beat_is_last = (beat_cnt == beats_m1);
    assign wr_beat      = {beat_is_last, bus.SAMPLE_DATA, half_data};

    // A read on the same edge frees a slot, so a full FIFO can still take the pair.
    assign pair_done    = sample_take & half_vld;
    assign beat_wr      = pair_done & (~fifo_full | pop);
    assign beat_drop    = pair_done & fifo_full & ~pop;

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arm_accept)              state_nxt = ST_RUN;
            ST_RUN:   if (beat_wr && beat_is_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_done)              state_nxt = ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = 1'b0;
        arm_accept  = 1'b0;
        arm_reject  = 1'b0;
        sample_take = 1'b0;
        drain_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                arm_accept = cfg_arm;
            end
            ST_RUN: begin
                busy        = 1'b1;
                arm_reject  = cfg_arm;
                sample_take = bus.SAMPLE_VALID;
            end
            ST_DRAIN: begin
                busy       = 1'b1;
                arm_reject = cfg_arm;
                drain_done = pop & out_last;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            beats_m1   <= '0;
            beat_cnt   <= '0;
            half_data  <= '0;
            half_vld   <= 1'b0;
            ovf_cnt    <= '0;
            pkt_done_r <= 1'b0;
            cfg_err_r  <= 1'b0;
        end else begin
            pkt_done_r <= drain_done;
            cfg_err_r  <= arm_reject;

            if (arm_accept) begin
                beats_m1 <= bus.CFG_WDATA[15:0];
                beat_cnt <= '0;
                half_vld <= 1'b0;
            end else if (cfg_clr) begin
                beats_m1 <= '0;
            end

            if (sample_take) begin
                if (!half_vld) begin
                    half_data <= bus.SAMPLE_DATA;
                    half_vld  <= 1'b1;
                end else begin
                    half_vld  <= 1'b0;
                end
            end

            if (beat_wr) begin
                beat_cnt <= beat_cnt + 16'd1;
            end

            if (beat_drop && (ovf_cnt != {OVF_WIDTH{1'b1}})) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (beat_wr) begin
            mem[wr_ptr] <= wr_beat;
        end
    end

    assign cnt_after_pop = count - (PTR_W+1)'(pop);
    assign rd_ptr_nxt    = rd_ptr + PTR_W'(pop);

    // Output register always holds the head entry; it bypasses the array when the FIFO would otherwise be empty.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            if (beat_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= rd_ptr_nxt;
            count   <= cnt_after_pop + (PTR_W+1)'(beat_wr);
            out_vld <= (cnt_after_pop != '0) | beat_wr;
            if (cnt_after_pop == '0) begin
                if (beat_wr) begin
                    out_data <= wr_beat[63:0];
                    out_last <= wr_beat[64];
                end
            end else begin
                out_data <= mem[rd_ptr_nxt][63:0];
                out_last <= mem[rd_ptr_nxt][64];
            end
        end
    end

    assign bus.M_AXIS_TDATA  = out_data;
    assign bus.M_AXIS_TKEEP  = 8'hFF;
    assign bus.M_AXIS_TVALID = out_vld;
    assign bus.M_AXIS_TLAST  = out_last;
    assign bus.BUSY          = busy;
    assign bus.PKT_DONE      = pkt_done_r;
    assign bus.CFG_ERR       = cfg_err_r;
    assign bus.OVF_CNT       = ovf_cnt;
endmodule

// File: tb/tb_s2mm_sample_packetizer.sv
// Randomized scoreboard bench for s2mm_sample_packetizer against a queue-based packet model.
module tb_s2mm_sample_packetizer;
    localparam int DEPTH = 16;
    localparam int OVFW  = 16;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    s2mm_sample_packetizer_if #(.OVF_WIDTH(OVFW)) bus ();

    s2mm_sample_packetizer #(.FIFO_DEPTH(DEPTH), .OVF_WIDTH(OVFW)) dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESET (rst),
        .bus           (bus.master)
    );

    // Reference model: FIFO contents as a queue, packet progress as plain integers.
    beat_t       mq[$];
    beat_t       exp_q[$];
    int          m_mode;      // 0 idle, 1 collecting, 2 draining
    int          m_m1;
    int          m_cnt;
    bit          m_half_v;
    logic [31:0] m_half;
    int          m_ovf;
    bit          m_done;
    bit          m_err;

    int checks   = 0;
    int failures = 0;
    int hs_beats = 0;
    int rdy_mode = 1;         // 0 stalled, 1 always ready, 2 random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        bit    pop;
        bit    full;
        int    nmode;
        beat_t b;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_mode = 0; m_m1 = 0; m_cnt = 0; m_half_v = 0;
            m_ovf = 0; m_done = 0; m_err = 0;
            return;
        end
        pop    = (mq.size() > 0) && bus.M_AXIS_TREADY;
        full   = (mq.size() == DEPTH);
        nmode  = m_mode;
        m_done = 0;
        m_err  = 0;
        if (m_mode == 2 && pop && mq[0].last) begin
            nmode  = 0;
            m_done = 1;
        end
        if (pop) void'(mq.pop_front());
        if (m_mode == 1 && bus.SAMPLE_VALID) begin
            if (!m_half_v) begin
                m_half   = bus.SAMPLE_DATA;
                m_half_v = 1;
            end else begin
                m_half_v = 0;
                if (full && !pop) begin
                    if (m_ovf < (1 << OVFW) - 1) m_ovf++;
                end else begin
                    b.data = {bus.SAMPLE_DATA, m_half};
                    b.last = (m_cnt == m_m1);
                    mq.push_back(b);
                    exp_q.push_back(b);
                    m_cnt++;
                    if (b.last) nmode = 2;
                end
            end
        end
        if (bus.CFG_WR) begin
            if (bus.CFG_WDATA[16]) begin
                if (m_mode == 0) begin
                    m_m1     = int'(bus.CFG_WDATA[15:0]);
                    m_cnt    = 0;
                    m_half_v = 0;
                    nmode    = 1;
                end else begin
                    m_err = 1;
                end
            end else begin
                m_m1 = 0;
            end
        end
        m_mode = nmode;
    endfunction

    task automatic tick(input bit cw, input logic [31:0] wd, input bit sv, input logic [31:0] sd);
        bus.CFG_WR       = cw;
        bus.CFG_WDATA    = wd;
        bus.SAMPLE_VALID = sv;
        bus.SAMPLE_DATA  = sd;
        case (rdy_mode)
            0:       bus.M_AXIS_TREADY = 1'b0;
            1:       bus.M_AXIS_TREADY = 1'b1;
            default: bus.M_AXIS_TREADY = 1'($urandom_range(0, 1));
        endcase
        model_step();
        @(posedge clk);
        #1;
        check("tvalid",   64'(bus.M_AXIS_TVALID), 64'(mq.size() > 0));
        check("busy",     64'(bus.BUSY),          64'(m_mode != 0));
        check("pkt_done", 64'(bus.PKT_DONE),      64'(m_done));
        check("cfg_err",  64'(bus.CFG_ERR),       64'(m_err));
        check("ovf_cnt",  64'(bus.OVF_CNT),       64'(m_ovf));
    endtask

    task automatic send_samples(input int n, input logic [31:0] start, input int pct, input bit rnd);
        int k;
        int guard;
        bit v;
        k = 0;
        guard = 0;
        while (k < n && guard < n * 50 + 100) begin
            v = ($urandom_range(0, 99) < pct);
            tick(0, 0, v, rnd ? 32'($urandom) : start + 32'(k));
            if (v) k++;
            guard++;
        end
    endtask

    task automatic feed_until_drain(input int budget, input int pct);
        int k;
        k = 0;
        while (m_mode == 1 && k < budget) begin
            tick(0, 0, ($urandom_range(0, 99) < pct), 32'($urandom));
            k++;
        end
        check("run_timeout", 64'(k < budget), 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((m_mode != 0 || mq.size() > 0) && k < budget) begin
            tick(0, 0, 1'($urandom_range(0, 1)), 32'($urandom));
            k++;
        end
        check("drain_timeout", 64'(k < budget), 64'd1);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst && bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
            hs_beats++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%h expected=none", bus.M_AXIS_TDATA);
            end else begin
                e = exp_q.pop_front();
                check("tdata", bus.M_AXIS_TDATA, e.data);
                check("tlast", 64'(bus.M_AXIS_TLAST), 64'(e.last));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          len_m1;
        logic [63:0] held;

        bus.CFG_WR = 0; bus.CFG_WDATA = 0; bus.SAMPLE_VALID = 0;
        bus.SAMPLE_DATA = 0; bus.M_AXIS_TREADY = 0;
        @(posedge clk);
        #1;

        // Reset
        rst = 1;
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 32'h55);
        rst = 0;
        check("rst_tkeep", 64'(bus.M_AXIS_TKEEP), 64'hFF);
        check("rst_tdata", bus.M_AXIS_TDATA, 64'h0);
        check("rst_tlast", 64'(bus.M_AXIS_TLAST), 64'h0);

        // Four-beat packet, back-to-back samples, always ready
        rdy_mode = 1;
        base = hs_beats;
        tick(1, 32'h0001_0003, 0, 0);
        tick(0, 0, 1, 32'h1);
        check("lat_pre_tvalid", 64'(bus.M_AXIS_TVALID), 64'h0);
        tick(0, 0, 1, 32'h2);
        check("lat_tvalid", 64'(bus.M_AXIS_TVALID), 64'h1);
        check("lat_tdata", bus.M_AXIS_TDATA, 64'h00000002_00000001);
        send_samples(6, 32'h3, 100, 0);
        wait_idle(50);
        check("pkt4_beats", 64'(hs_beats - base), 64'd4);

        // Single-beat packet, then a stray sample after the pair
        base = hs_beats;
        tick(1, 32'h0001_0000, 0, 0);
        tick(0, 0, 1, 32'h11);
        tick(0, 0, 1, 32'h12);
        tick(0, 0, 1, 32'h13);
        wait_idle(50);
        tick(0, 0, 1, 32'h14);
        tick(0, 0, 0, 0);
        check("pkt1_beats", 64'(hs_beats - base), 64'd1);
        check("pkt1_ovf", 64'(bus.OVF_CNT), 64'd0);

        // Overflow: 20-beat packet, downstream stalled for 40 samples
        base = hs_beats;
        rdy_mode = 0;
        tick(1, 32'h0001_0013, 0, 0);
        send_samples(40, 32'h100, 100, 0);
        held = bus.M_AXIS_TDATA;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        check("ovf_count", 64'(bus.OVF_CNT), 64'd4);
        check("stall_head", bus.M_AXIS_TDATA, 64'h00000101_00000100);
        check("stall_stable", bus.M_AXIS_TDATA, held);
        rdy_mode = 1;
        send_samples(8, 32'h200, 100, 0);
        wait_idle(100);
        check("ovf_beats", 64'(hs_beats - base), 64'd20);

        // Arm write while busy is rejected and does not change the length
        base = hs_beats;
        tick(1, 32'h0001_0001, 0, 0);
        send_samples(2, 32'h300, 100, 0);
        tick(1, 32'h0001_0003, 0, 0);
        check("cfg_err_pulse", 64'(bus.CFG_ERR), 64'h1);
        send_samples(2, 32'h302, 100, 0);
        wait_idle(50);
        check("rejected_arm_beats", 64'(hs_beats - base), 64'd2);

        // Reset mid-packet
        rdy_mode = 0;
        tick(1, 32'h0001_0003, 0, 0);
        send_samples(4, 32'h400, 100, 0);
        tick(1, 32'h0000_0000, 0, 0);
        check("clr_keeps_busy", 64'(bus.BUSY), 64'h1);
        rst = 1;
        tick(0, 0, 0, 0);
        rst = 0;
        check("midrst_tvalid", 64'(bus.M_AXIS_TVALID), 64'h0);
        check("midrst_busy", 64'(bus.BUSY), 64'h0);
        check("midrst_ovf", 64'(bus.OVF_CNT), 64'h0);
        rdy_mode = 1;
        base = hs_beats;
        tick(1, 32'h0001_0001, 0, 0);
        send_samples(4, 32'h500, 100, 0);
        wait_idle(50);
        check("post_rst_beats", 64'(hs_beats - base), 64'd2);

        // Random short packets with random ready and sparse samples
        rdy_mode = 2;
        for (int p = 0; p < 6; p++) begin
            len_m1 = $urandom_range(0, 30);
            base = hs_beats;
            tick(1, 32'h0001_0000 | 32'(len_m1), 0, 0);
            feed_until_drain(2000, $urandom_range(30, 100));
            wait_idle(200);
            check("rand_pkt_beats", 64'(hs_beats - base), 64'(len_m1 + 1));
        end

        // Long packet, random ready, dense random samples
        base = hs_beats;
        tick(1, 32'h0001_0FFF, 0, 0);
        feed_until_drain(40000, 80);
        wait_idle(200);
        check("long_pkt_beats", 64'(hs_beats - base), 64'd4096);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/s2mm_sample_packetizer.md
Name: s2mm_sample_packetizer

Overview:
- Upstream stage of the DMA-programming master: it produces the AXI4-Stream packets that the AXI DMA S2MM channel writes into each DDR buffer.
- Accepts 32-bit samples, packs sample pairs into 64-bit beats and buffers them in a FIFO.
- Emits one packet of programmed length per arm, with TLAST on the final beat.
- The arm command is the control-register write the master issues last in its sequence (value = beats-1 + 0x10000).

Parameters:
- FIFO_DEPTH, 16, output FIFO depth in 64-bit beats; power of 2, minimum 4.
- OVF_WIDTH, 16, width of the saturating overflow counter.

Ports:
- M_AXIS_ACLK  in  1  single clock for all logic.
- M_AXIS_ARESET  in  1  synchronous, active-high reset.
- CFG_WR  in  1  one-cycle control-register write strobe.
- CFG_WDATA  in  32  control word: [16]=arm, [15:0]=beats_m1, [31:17] ignored.
- SAMPLE_DATA  in  32  input sample.
- SAMPLE_VALID  in  1  sample qualifier; no backpressure on this interface.
- M_AXIS_TDATA  out  64  packed beat: [31:0]=earlier sample, [63:32]=later sample.
- M_AXIS_TKEEP  out  8  constant 8'hFF.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  final beat of the packet.
- BUSY  out  1  high in RUN or DRAIN.
- PKT_DONE  out  1  one-cycle pulse at packet completion.
- CFG_ERR  out  1  one-cycle pulse when an arm write is rejected.
- OVF_CNT  out  OVF_WIDTH  count of dropped sample pairs; saturates.

Behaviour:
- Reset (sampled on M_AXIS_ACLK while M_AXIS_ARESET=1):
  - State goes to IDLE; FIFO is emptied; pack half-register is cleared; beat counter = 0; beats_m1 register = 0.
  - All outputs are 0 except TKEEP = 8'hFF.
  - Reset mid-packet abandons the packet immediately; TVALID drops in the same edge.
- Configuration writes (CFG_WR=1):
  - arm=0: beats_m1 register := 0. No state change in any state.
  - arm=1 in IDLE: beats_m1 := CFG_WDATA[15:0]; beat counter := 0; half-register cleared; next state = RUN.
  - arm=1 in RUN or DRAIN: write ignored; CFG_ERR pulses the next cycle.
- State IDLE:
  - SAMPLE_VALID is ignored; samples are neither packed nor counted as overflow.
- State RUN:
  - First sample of a pair is latched into the half-register.
  - Second sample plus the half-register forms one beat, written into the FIFO on that same edge. The FIFO entry is 65 bits: data plus last flag (last = beat counter == beats_m1).
  - After each beat is written, the beat counter increments.
  - When the last-flagged beat is written, next state = DRAIN.
  - If the pair completes while the FIFO is full: the pair is dropped, the half-register is cleared, the beat counter is unchanged, and OVF_CNT increments (holds at all-ones).
- State DRAIN:
  - SAMPLE_VALID is ignored.
  - Leaves DRAIN on the cycle the last-flagged beat handshakes (TVALID & TREADY & TLAST). Next state = IDLE; PKT_DONE pulses the following cycle.
- FIFO and output:
  - First-word-fall-through with registered outputs.
  - Latency: the beat is on TDATA with TVALID=1 in the cycle after the SAMPLE_VALID cycle of the pair's second sample (FIFO initially empty).
  - TVALID, TDATA and TLAST are held stable until TREADY=1. TVALID never drops without a handshake, except on reset.
  - Sustains one beat per clock when TREADY=1.
  - A simultaneous write and read on a full FIFO is allowed: the read frees the slot, so no overflow.
  - Full = FIFO_DEPTH entries; empty = 0 entries.
- Arithmetic:
  - Packet length = beats_m1 + 1 beats, range 1..65536, consuming 2*(beats_m1+1) samples.
  - The beat counter is 16 bits and never wraps within a packet.
- OVF_CNT is cleared only by reset.

Test Plan:
- Arm with 0x10003, 8 samples 0x1..0x8 back-to-back, TREADY=1 -> 4 beats: 0x00000002_00000001, 0x00000004_00000003, 0x00000006_00000005, 0x00000008_00000007. TLAST on beat 4 only. PKT_DONE one cycle after beat 4. BUSY falls. First TVALID exactly 1 cycle after sample 2.
- Arm 0x10000 (1 beat), then 2 samples -> single beat with TLAST=1. A third sample while in DRAIN/IDLE produces no beat and OVF_CNT stays 0.
- FIFO_DEPTH=16, arm 0x10013 (20 beats), TREADY=0, 40 samples -> 16 beats buffered and OVF_CNT=4. Then TREADY=1 and 8 more samples -> 20 beats total, TLAST on the 20th. Data is stable while stalled.
- Arm write 0x10003 during RUN -> CFG_ERR pulse, packet length stays as originally programmed. Write of 0x0 during RUN -> no state change.
- Assert M_AXIS_ARESET after 2 of 4 beats with TREADY=0 -> next cycle TVALID=0, BUSY=0, OVF_CNT=0. A fresh arm 0x10001 then produces a clean 2-beat packet.
- Random TREADY (50%) with continuous samples over a 65536-beat packet (0x1FFFF) -> exactly 65536 beats, TLAST only on the last one, no lost or duplicated data when OVF_CNT=0.
